dct_quant_zigzag: RTL and testbench
===================================

# dct_quant_zigzag

Quantization and zigzag reorder stage placed directly downstream of `twoD_DCT`. It accepts one 8-coefficient row of 2-D DCT output per valid beat and quantizes each coefficient by the JPEG luma table using a reciprocal multiply. It stores an 8x8 block in a ping-pong buffer, then streams the 64 quantized coefficients out one per transfer in zigzag order under a valid/ready handshake, feeding the run-length/entropy coder.

## Interface
- `COEF_W`, default 12: coefficient width, input and output, signed.
- `RECIP_W`, default 17: reciprocal width, unsigned; R = round(65536/Q).
- `i_clk`, input, 1: clock. All logic is on the rising edge.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_valid`, input, 1: the row beat on `i_data0..7` is valid.
- `i_data0..i_data7`, input, `COEF_W` each: one DCT row; `i_dataN` is column N.
- `o_in_ready`, output, 1: a write bank is free or partially filled. Advisory to the upstream scheduler.
- `o_overflow`, output, 1: sticky. A beat arrived with no writable bank.
- `o_valid`, output, 1: output coefficient is valid.
- `i_ready`, input, 1: downstream accepts the coefficient.
- `o_data`, output, `COEF_W`: quantized coefficient, signed.
- `o_index`, output, 6: zigzag index k, 0..63.
- `o_last`, output, 1: high with k=63.

## Operation
- **Write side.**
  - A row counter wr_row (0..7) and a write-bank pointer wr_bank track block assembly.
  - Each accepted beat is quantized, then stored as raster row wr_row of bank wr_bank.
  - After row 7 the bank is marked full, wr_bank toggles and wr_row resets to 0.
- **Drop rule.** If i_valid arrives while the target bank is still full (unread), the beat is dropped, o_overflow sets, and wr_row does not advance.
- **Quantization.**
  - Per lane, with raster position p = 8*row + col: q = sign(c) * ((|c| * R[p] + 2^15) >> 16).
  - Rounding is symmetric half-away-from-zero.
  - The product is 29 bits unsigned.
  - The result always fits in `COEF_W`, because Q ≥ 1 and |c| ≤ 2048.
  - -2048 with Q=1 yields -2048.
- **Read side.** This is a state machine with states IDLE and STREAM.
  - IDLE -> STREAM when the read bank is full.
  - In STREAM, k counts 0..63 and reads raster position ZZ[k] of the read bank.
  - Each o_valid && i_ready transfer advances k.
  - The transfer with k=63 marks the bank empty and toggles the read pointer.
  - After that transfer the machine goes to STREAM again if the other bank is full, otherwise to IDLE.
- **Handshake.**
  - o_data, o_index and o_last are held stable while o_valid && !i_ready.
  - o_valid never drops without a transfer, except on reset.
- **Simultaneous events.**
  - The writer completing bank X and the reader finishing bank Y in the same cycle are both honoured.
  - A bank freed by the last read is writable starting the next edge.
- **Reset.** Outputs go to o_valid=0, o_data=0, o_index=0, o_last=0, o_overflow=0, o_in_ready=1. Both banks become empty and all pointers and counters go to 0. Reset mid-block discards any partial block and any block being streamed.

## Timing
- Quantization is a one-register pipeline.
- A beat sampled at edge E is written to the bank at E+1. If it is row 7, the bank is full after E+1.
- First o_valid is high after edge E+2: 2 cycles from the last row beat.
- With i_ready held at 1, the output delivers 1 coefficient per cycle, and the 64 coefficients take 64 consecutive cycles.
- For the next block to be back-to-back, it must complete during the current stream.
- Sustained input rate is at most 8 beats per 64 cycles.

## Configuration
- `DCT_QUANT_EN`
  - Defined: quantization as above.
  - Undefined: the quantizer lanes are removed, and the coefficient passes unchanged to the buffer with the same one-register latency. Zigzag order and handshake are unchanged.

## Structure
- Shared package `dct_pkg` holds:
  - `COEF_W` and `RECIP_W`;
  - the 64-entry zigzag LUT ZZ[k] giving the raster position;
  - the 64-entry luma Q table and its reciprocal table R, derived as constants.
- One sub-module, `zz_quant_lane`:
  - one coefficient, |c|*R, rounding, sign restore, output register;
  - instantiated 8 times, one per column.

## Test plan
- **DC quantization.** Row 0 = {160,0,...,0}, rows 1..7 zero, i_ready=1.
  - Required: k=0 gives o_data=10 (Q=16); k=1..63 give 0.
  - o_last is high only with k=63.
- **Symmetric rounding.** Raster p=0 values 8, -8, 7.
  - Required: outputs 1, -1, 0.
- **Zigzag order.** Each raster p is loaded with value p, under `DCT_QUANT_EN` undefined.
  - Required: the o_data sequence begins 0,1,8,16,9,2,3,10 and ends 62,63.
- **Backpressure.** i_ready toggles 1,0,0,1 repeatedly.
  - Required: 64 transfers, in order, with no duplicates.
  - Outputs are stable while stalled.
- **Ping-pong and overflow.** Send 2 blocks back-to-back, then a third immediately, with i_ready=0.
  - Required: o_in_ready=0 after block 2.
  - The third block's beats are dropped and o_overflow is 1.
  - Once i_ready=1, blocks 1 and 2 stream intact.
- **Reset mid-stream.** Assert i_rst at k=20.
  - Required: next cycle o_valid=0 and o_overflow=0.
  - A new block then streams from k=0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants for the DCT quantize/zigzag stage.
//   COEF_W / RECIP_W : default coefficient and reciprocal widths
//   ZZ[k]            : raster position (8*row+col) read at zigzag index k
//   QTAB[p]          : JPEG luma quantizer for raster position p
//   recip(q)         : round(65536/q), used to build the reciprocal ROMs
//   rd_state_t       : read-side FSM states
package dct_pkg;

   localparam int COEF_W  = 12;
   localparam int RECIP_W = 17;

   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   localparam int unsigned QTAB [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99};

   // Elaboration-time only: rounds to nearest so |c|*R stays close to 65536*|c|/Q.
   function automatic int unsigned recip(input int unsigned q);
      return (32'd65536 + q / 2) / q;
   endfunction

   typedef enum logic {IDLE, STREAM} rd_state_t;

endpackage

// File: rtl/zz_quant_lane.sv
// One quantizer lane: q = sign(c) * ((|c|*R + 2^15) >> 16), registered.
// With DCT_QUANT_EN undefined the lane is a plain enabled register (c passes unchanged).
// Ports:
//   clk   : rising-edge clock
//   en    : load the output register this cycle
//   coef  : signed input coefficient
//   recip : reciprocal of the quantizer for this lane's raster position
//   q     : registered (quantized) coefficient
module zz_quant_lane #(
   parameter int COEF_W  = dct_pkg::COEF_W,
   parameter int RECIP_W = dct_pkg::RECIP_W
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic signed [COEF_W-1:0]  coef,
   input  logic        [RECIP_W-1:0] recip,
   output logic signed [COEF_W-1:0]  q
);

`ifdef DCT_QUANT_EN
   localparam int PW = COEF_W + RECIP_W;

   logic              neg;
   logic [COEF_W-1:0] mag, qmag, qv;
   logic [PW-1:0]     prod, rnd;

   // Work on the magnitude so rounding is symmetric; -2^(W-1) maps to 2^(W-1) unsigned.
   assign neg  = coef[COEF_W-1];
   assign mag  = neg ? COEF_W'(-coef) : COEF_W'(coef);
   assign prod = PW'(mag) * PW'(recip);
   assign rnd  = prod + PW'(32'h8000);
   assign qmag = COEF_W'(rnd >> 16);
   assign qv   = neg ? -qmag : qmag;

   always_ff @(posedge clk)
      if (en) q <= qv;
`else
   logic unused_recip;
   assign unused_recip = ^recip;

   always_ff @(posedge clk)
      if (en) q <= coef;
`endif

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantize 8-wide DCT rows into a ping-pong 8x8 buffer and stream the block out in zigzag order.
// Optional feature macro: DCT_QUANT_EN (defined = quantize, undefined = pass coefficients through).
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid, i_data0..7 : one row beat, i_dataN = column N
//   o_in_ready          : current write bank is not full (advisory)
//   o_overflow          : sticky, a beat arrived while the write bank was full
//   o_valid, i_ready    : output handshake
//   o_data, o_index     : coefficient and its zigzag index k
//   o_last              : high with k = 63
module dct_quant_zigzag #(
   parameter int COEF_W  = dct_pkg::COEF_W,
   parameter int RECIP_W = dct_pkg::RECIP_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [COEF_W-1:0] i_data0,
   input  logic [COEF_W-1:0] i_data1,
   input  logic [COEF_W-1:0] i_data2,
   input  logic [COEF_W-1:0] i_data3,
   input  logic [COEF_W-1:0] i_data4,
   input  logic [COEF_W-1:0] i_data5,
   input  logic [COEF_W-1:0] i_data6,
   input  logic [COEF_W-1:0] i_data7,
   output logic              o_in_ready,
   output logic              o_overflow,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [COEF_W-1:0] o_data,
   output logic [5:0]        o_index,
   output logic              o_last
);
   import dct_pkg::*;

   logic [7:0][COEF_W-1:0] din, qout;
   logic [1:0]             full;
   logic                   wr_bank, rd_bank, bank_q;
   logic [2:0]             wr_row, row_q;
   logic                   accept, wr_vld;
   logic [COEF_W-1:0]      mem [2][64];
   rd_state_t              state, state_nxt;
   logic [5:0]             k;
   logic                   xfer, blk_done;

   assign din        = {i_data7, i_data6, i_data5, i_data4, i_data3, i_data2, i_data1, i_data0};
   assign accept     = i_valid && !full[wr_bank];
   assign o_in_ready = !full[wr_bank];

   // Each column gets an 8-entry reciprocal ROM indexed by the row being written.
   for (genvar c = 0; c < 8; c++) begin : g_lane
      logic [7:0][RECIP_W-1:0] rlut;
      for (genvar r = 0; r < 8; r++) begin : g_row
         localparam int unsigned RV = recip(QTAB[8*r+c]);
         assign rlut[r] = RECIP_W'(RV);
      end
      zz_quant_lane #(.COEF_W(COEF_W), .RECIP_W(RECIP_W)) u_lane (
         .clk   (i_clk),
         .en    (accept),
         .coef  (din[c]),
         .recip (rlut[wr_row]),
         .q     (qout[c])
      );
   end

   // Write side: row/bank are captured alongside the lane registers and used one edge later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_row     <= '0;
         wr_bank    <= 1'b0;
         wr_vld     <= 1'b0;
         row_q      <= '0;
         bank_q     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         wr_vld <= accept;
         if (accept) begin
            row_q  <= wr_row;
            bank_q <= wr_bank;
            wr_row <= wr_row + 3'd1;
            if (wr_row == 3'd7) wr_bank <= ~wr_bank;
         end
         if (i_valid && full[wr_bank]) o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk)
      if (wr_vld)
         for (int c = 0; c < 8; c++) mem[bank_q][{row_q, 3'(c)}] <= qout[c];

   // The writer only targets non-full banks and the reader only finishes full ones,
   // so the set and the clear never hit the same bank in one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) full <= '0;
      else begin
         if (wr_vld && row_q == 3'd7) full[bank_q] <= 1'b1;
         if (blk_done)                full[rd_bank] <= 1'b0;
      end
   end

   // Read FSM: state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         k       <= '0;
         rd_bank <= 1'b0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            k <= k + 6'd1;
            if (k == 6'd63) rd_bank <= ~rd_bank;
         end
      end
   end

   // Read FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (full[rd_bank]) state_nxt = STREAM;
         STREAM:  if (blk_done) state_nxt = full[~rd_bank] ? STREAM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read FSM: outputs. The streamed bank is frozen while full, so o_data holds under stall.
   always_comb begin
      o_valid = 1'b0;
      o_data  = '0;
      o_index = '0;
      o_last  = 1'b0;
      if (state == STREAM) begin
         o_valid = 1'b1;
         o_data  = mem[rd_bank][ZZ[k]];
         o_index = k;
         o_last  = (k == 6'd63);
      end
   end

   assign xfer     = o_valid && i_ready;
   assign blk_done = xfer && (k == 6'd63);

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed self-checking bench for dct_quant_zigzag (expectations follow DCT_QUANT_EN).
module tb_dct_quant_zigzag;
   localparam int W = 12;

`ifdef DCT_QUANT_EN
   localparam int DC_EXP   = 10;   // 160 / 16
   localparam int B63_EXP  = 2;    // 198 * 662 rounds to 2
   localparam int RND_EXP [3] = '{1, -1, 0};
`else
   localparam int DC_EXP   = 160;
   localparam int B63_EXP  = 198;
   localparam int RND_EXP [3] = '{8, -8, 7};
`endif
   localparam int RND_IN [3] = '{8, -8, 7};

   localparam int ZZ_REF [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   logic          clk = 1'b0;
   logic          rst, valid, ready;
   logic [W-1:0]  d [8];
   logic          in_ready, ovf, o_valid, o_last;
   logic [W-1:0]  o_data;
   logic [5:0]    o_index;
   logic signed [W-1:0] blk [64];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   dct_quant_zigzag dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid),
      .i_data0(d[0]), .i_data1(d[1]), .i_data2(d[2]), .i_data3(d[3]),
      .i_data4(d[4]), .i_data5(d[5]), .i_data6(d[6]), .i_data7(d[7]),
      .o_in_ready(in_ready), .o_overflow(ovf), .o_valid(o_valid), .i_ready(ready),
      .o_data(o_data), .o_index(o_index), .o_last(o_last)
   );

   // Drive the 8 rows of blk on consecutive cycles; valid stays high on return.
   task automatic send_block();
      for (int r = 0; r < 8; r++) begin
         @(posedge clk); #1;
         valid = 1'b1;
         for (int c = 0; c < 8; c++) d[c] = blk[8*r+c];
      end
   endtask

   task automatic idle_in();
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic clear_blk();
      for (int p = 0; p < 64; p++) blk[p] = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
      checks++; if (o_data !== '0) begin errors++; $display("FAIL rst_data got %0d want 0", o_data); end
      checks++; if (o_index !== 6'd0) begin errors++; $display("FAIL rst_index got %0d want 0", o_index); end
      checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", o_last); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_dc();
      int e;
      clear_blk(); blk[0] = 160; ready = 1'b1;
      send_block(); idle_in();
      @(negedge clk);   // after row-7 edge
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL dc_lat1 got %b want 0", o_valid); end
      @(negedge clk);   // after +1
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL dc_lat2 got %b want 0", o_valid); end
      @(negedge clk);   // after +2
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL dc_lat3 got %b want 1", o_valid); end
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         e = (k == 0) ? DC_EXP : 0;
         checks++;
         if (o_valid !== 1'b1 || o_index !== 6'(k) || o_data !== W'(e) || o_last !== (k == 63)) begin
            errors++;
            $display("FAIL dc k=%0d got v=%b i=%0d d=%0d l=%b want d=%0d", k, o_valid, o_index,
                     $signed(o_data), o_last, e);
         end
      end
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL dc_end_valid got %b want 0", o_valid); end
   endtask

   task automatic test_rounding();
      int n;
      for (int t = 0; t < 3; t++) begin
         clear_blk(); blk[0] = W'(RND_IN[t]); ready = 1'b1;
         send_block(); idle_in();
         n = 0;
         @(negedge clk);
         while (!o_valid && n < 10) begin @(negedge clk); n++; end
         checks++;
         if (o_valid !== 1'b1 || o_index !== 6'd0 || o_data !== W'(RND_EXP[t])) begin
            errors++;
            $display("FAIL round in=%0d got v=%b i=%0d d=%0d want d=%0d", RND_IN[t], o_valid, o_index,
                     $signed(o_data), RND_EXP[t]);
         end
         n = 0;
         while (!(o_valid && o_last) && n < 80) begin @(negedge clk); n++; end
         checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL round_drain got %b want 1", o_last); end
      end
   endtask

   task automatic test_zigzag();
      int n;
      for (int p = 0; p < 64; p++) blk[p] = W'(p);
      ready = 1'b1;
      send_block(); idle_in();
      n = 0;
      @(negedge clk);
      while (!o_valid && n < 10) begin @(negedge clk); n++; end
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_index !== 6'(k) || o_last !== (k == 63)) begin
            errors++;
            $display("FAIL zz_ctl k=%0d got v=%b i=%0d l=%b", k, o_valid, o_index, o_last);
         end
`ifndef DCT_QUANT_EN
         checks++;
         if (o_data !== W'(ZZ_REF[k])) begin
            errors++; $display("FAIL zz_data k=%0d got %0d want %0d", k, o_data, ZZ_REF[k]);
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      int got;
      logic prev_xfer, have_prev, pl;
      logic [W-1:0] pd;
      logic [5:0] pi;
      got = 0; have_prev = 1'b0; prev_xfer = 1'b1; pd = '0; pi = '0; pl = 1'b0;
      for (int p = 0; p < 64; p++) blk[p] = W'(p);
      ready = 1'b1;
      send_block(); idle_in();
      for (int cyc = 0; cyc < 400 && got < 64; cyc++) begin
         ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(negedge clk);
         if (o_valid) begin
            if (have_prev && !prev_xfer) begin
               checks++;
               if (o_data !== pd || o_index !== pi || o_last !== pl) begin
                  errors++;
                  $display("FAIL bp_stable got i=%0d d=%0d l=%b want i=%0d d=%0d l=%b",
                           o_index, o_data, o_last, pi, pd, pl);
               end
            end
            if (ready) begin
               checks++;
               if (o_index !== 6'(got) || o_last !== (got == 63)) begin
                  errors++; $display("FAIL bp_order got i=%0d l=%b want i=%0d", o_index, o_last, got);
               end
`ifndef DCT_QUANT_EN
               checks++;
               if (o_data !== W'(ZZ_REF[got])) begin
                  errors++; $display("FAIL bp_data k=%0d got %0d want %0d", got, o_data, ZZ_REF[got]);
               end
`endif
               got++;
            end
            prev_xfer = ready; have_prev = 1'b1; pd = o_data; pi = o_index; pl = o_last;
         end
         @(posedge clk); #1;
      end
      checks++; if (got !== 64) begin errors++; $display("FAIL bp_count got %0d want 64", got); end
      ready = 1'b1;
   endtask

   task automatic test_pingpong();
      int e, k;
      ready = 1'b0;
      clear_blk(); blk[0] = 160;
      send_block();
      clear_blk(); blk[0] = -160; blk[63] = 198;
      send_block(); idle_in();
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_in_ready got %b want 0", in_ready); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf_pre got %b want 0", ovf); end
      checks++;
      if (o_valid !== 1'b1 || o_index !== 6'd0) begin
         errors++; $display("FAIL pp_stall got v=%b i=%0d want v=1 i=0", o_valid, o_index);
      end
      for (int p = 0; p < 64; p++) blk[p] = 100;
      send_block(); idle_in();
      @(negedge clk);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pp_ovf got %b want 1", ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_in_ready2 got %b want 0", in_ready); end
      ready = 1'b1;
      for (int n = 0; n < 128; n++) begin
         if (n > 0) @(negedge clk);
         k = n % 64;
         if (k == 0)                e = (n < 64) ? DC_EXP : -DC_EXP;
         else if (k == 63 && n > 63) e = B63_EXP;
         else                       e = 0;
         checks++;
         if (o_valid !== 1'b1 || o_index !== 6'(k) || o_data !== W'(e) || o_last !== (k == 63)) begin
            errors++;
            $display("FAIL pp n=%0d got v=%b i=%0d d=%0d l=%b want i=%0d d=%0d", n, o_valid, o_index,
                     $signed(o_data), o_last, k, e);
         end
      end
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pp_end_valid got %b want 0", o_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_end_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_midstream();
      int n, got;
      for (int p = 0; p < 64; p++) blk[p] = W'(p);
      ready = 1'b1;
      send_block(); idle_in();
      n = 0;
      @(negedge clk);
      while (!(o_valid && o_index == 6'd20) && n < 100) begin @(negedge clk); n++; end
      checks++; if (o_index !== 6'd20) begin errors++; $display("FAIL mr_reach got %0d want 20", o_index); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mr_ovf_sticky got %b want 1", ovf); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", o_valid); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mr_ovf got %b want 0", ovf); end
      checks++; if (o_index !== 6'd0) begin errors++; $display("FAIL mr_index got %0d want 0", o_index); end
      rst = 1'b0;
      clear_blk(); blk[0] = 160;
      send_block(); idle_in();
      n = 0;
      @(negedge clk);
      while (!o_valid && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (o_valid !== 1'b1 || o_index !== 6'd0 || o_data !== W'(DC_EXP)) begin
         errors++;
         $display("FAIL mr_restart got v=%b i=%0d d=%0d want i=0 d=%0d", o_valid, o_index, o_data, DC_EXP);
      end
      got = 0;
      for (int c = 0; c < 100 && !(o_valid && o_last); c++) begin
         if (o_valid) got++;
         @(negedge clk);
      end
      checks++;
      if (got !== 63 || o_index !== 6'd63) begin
         errors++; $display("FAIL mr_len got %0d idx=%0d want 63 idx=63", got, o_index);
      end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; ready = 1'b0;
      for (int c = 0; c < 8; c++) d[c] = '0;
      clear_blk();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_dc();
      test_rounding();
      test_zigzag();
      test_backpressure();
      test_pingpong();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
